// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu
//  Purpose  : Execute-stage multiply/divide unit. Holds the architectural
//             HI/LO pair and runs mult/multu/div/divu as fixed-latency
//             multi-cycle operations. Exposes a busy flag for hazard stalls
//             and an mfhi/mflo read result for the E-stage result mux.
//  Ports    : clk      - clock, rising edge
//             reset    - synchronous, active-high reset
//             E_MDUOp  - 0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                        7 mfhi,8 mflo (9 madd,10 maddu,11 msub,12 msubu
//                        when MDU_MADD_EN is defined)
//             E_Start  - one-cycle launch pulse for multi-cycle ops
//             E_A/E_B  - rs/rt operands
//             E_Busy   - registered, high while an op is in flight
//             E_HI/E_LO- current HI/LO registers
//             E_MDURe  - HI for op 7, LO for op 8, else 0 (combinational)
//  Options  : `define MDU_MADD_EN adds the multiply-accumulate ops 9..12.
//  Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_MDUOp,
    input  logic        E_Start,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    output logic        E_Busy,
    output logic [31:0] E_HI,
    output logic [31:0] E_LO,
    output logic [31:0] E_MDURe
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt,   w_cnt_next;
    logic [3:0]  r_op,    w_op_next;
    logic [63:0] r_res,   w_res_next;
    logic        r_bzero, w_bzero_next;
    logic [31:0] r_hi,    w_hi_next;
    logic [31:0] r_lo,    w_lo_next;

    // ------------------------------------------------------------------
    // Datapath: the full result is formed from the live operands at the
    // launch edge and parked in r_res until the counter expires.
    // ------------------------------------------------------------------
    logic signed [63:0] w_smul;
    logic        [63:0] w_umul;
    logic               w_b_zero;
    logic               w_sdiv_ovf;
    logic        [31:0] w_sdiv_b;
    logic        [31:0] w_udiv_b;
    logic signed [31:0] w_sq, w_sr;
    logic        [31:0] w_uq, w_ur;
    logic               w_op_valid;
    logic               w_launch;
    logic               w_is_div_op;

    assign w_smul = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
    assign w_umul = {32'd0, E_A} * {32'd0, E_B};

    // Divisors are substituted with 1 where the true division is undefined
    // (zero divisor) or overflows (most-negative / -1). For the overflow
    // case, dividing by 1 yields exactly the required quotient 0x80000000
    // and remainder 0; zero-divisor results are discarded at completion.
    assign w_b_zero   = (E_B == 32'd0);
    assign w_sdiv_ovf = (E_A == 32'h8000_0000) && (E_B == 32'hFFFF_FFFF);
    assign w_sdiv_b   = (w_b_zero || w_sdiv_ovf) ? 32'd1 : E_B;
    assign w_udiv_b   = w_b_zero ? 32'd1 : E_B;

    assign w_sq = $signed(E_A) / $signed(w_sdiv_b);
    assign w_sr = $signed(E_A) % $signed(w_sdiv_b);
    assign w_uq = E_A / w_udiv_b;
    assign w_ur = E_A % w_udiv_b;

    always_comb begin
        w_op_valid = 1'b0;
        case (E_MDUOp)
            4'd1, 4'd2, 4'd3, 4'd4: w_op_valid = 1'b1;
`ifdef MDU_MADD_EN
            4'd9, 4'd10, 4'd11, 4'd12: w_op_valid = 1'b1;
`endif
            default: w_op_valid = 1'b0;
        endcase
    end

    assign w_launch    = (r_state == S_IDLE) && E_Start && w_op_valid;
    assign w_is_div_op = (r_op == 4'd3) || (r_op == 4'd4);

    // ------------------------------------------------------------------
    // Next-state / next-register logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_op_next    = r_op;
        w_res_next   = r_res;
        w_bzero_next = r_bzero;
        w_hi_next    = r_hi;
        w_lo_next    = r_lo;

        case (r_state)
            S_IDLE: begin
                if (w_launch) begin
                    w_state_next = S_RUN;
                    w_op_next    = E_MDUOp;
                    w_bzero_next = w_b_zero;
                    w_cnt_next   = (E_MDUOp == 4'd3 || E_MDUOp == 4'd4) ? c_div_cnt : c_mult_cnt;
                    case (E_MDUOp)
                        4'd1:    w_res_next = w_smul;
                        4'd2:    w_res_next = w_umul;
                        4'd3:    w_res_next = {w_sr, w_sq};
                        4'd4:    w_res_next = {w_ur, w_uq};
`ifdef MDU_MADD_EN
                        4'd9, 4'd11:  w_res_next = w_smul;
                        4'd10, 4'd12: w_res_next = w_umul;
`endif
                        default: w_res_next = 64'd0;
                    endcase
                end else if (E_MDUOp == 4'd5) begin
                    w_hi_next = E_A;
                end else if (E_MDUOp == 4'd6) begin
                    w_lo_next = E_A;
                end
            end

            S_RUN: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_next = S_IDLE;
`ifdef MDU_MADD_EN
                    // Accumulate against HI/LO as they stand now; they
                    // cannot have changed while the op was in flight.
                    if (r_op >= 4'd9) begin
                        if (r_op >= 4'd11)
                            {w_hi_next, w_lo_next} = {r_hi, r_lo} - r_res;
                        else
                            {w_hi_next, w_lo_next} = {r_hi, r_lo} + r_res;
                    end else
`endif
                    if (!(w_is_div_op && r_bzero)) begin
                        {w_hi_next, w_lo_next} = r_res;
                    end
                end
            end

            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_op    <= 4'd0;
            r_res   <= 64'd0;
            r_bzero <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_op    <= w_op_next;
            r_res   <= w_res_next;
            r_bzero <= w_bzero_next;
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign E_Busy = (r_state == S_RUN);
    assign E_HI   = r_hi;
    assign E_LO   = r_lo;

    always_comb begin
        case (E_MDUOp)
            4'd7:    E_MDURe = r_hi;
            4'd8:    E_MDURe = r_lo;
            default: E_MDURe = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_mdu
//  Purpose  : Directed self-checking bench for e_mdu (default parameters).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  E_MDUOp;
    logic        E_Start;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        E_Busy;
    logic [31:0] E_HI;
    logic [31:0] E_LO;
    logic [31:0] E_MDURe;

    int n_tests = 0;
    int n_fail  = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .E_MDUOp (E_MDUOp),
        .E_Start (E_Start),
        .E_A     (E_A),
        .E_B     (E_B),
        .E_Busy  (E_Busy),
        .E_HI    (E_HI),
        .E_LO    (E_LO),
        .E_MDURe (E_MDURe)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        E_MDUOp = op; E_A = a; E_B = b; E_Start = 1'b1;
        tick();
        E_Start = 1'b0; E_MDUOp = 4'd0;
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a);
        E_MDUOp = op; E_A = a;
        tick();
        E_MDUOp = 4'd0;
    endtask

    // Counts cycles observed busy; bounded so a stuck flag cannot hang.
    task automatic count_busy(output int n);
        n = 0;
        while (E_Busy && n < 40) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; E_MDUOp = 4'd0; E_Start = 1'b0; E_A = 32'd0; E_B = 32'd0;
        tick(); tick();
        reset = 1'b0;
        n_tests++; if (E_Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", E_Busy); end
        n_tests++; if (E_HI !== 32'd0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", E_HI); end
        n_tests++; if (E_LO !== 32'd0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", E_LO); end
        n_tests++; if (E_MDURe !== 32'd0) begin n_fail++; $display("FAIL reset_mdure: got %h expected 0", E_MDURe); end
    endtask

    task automatic test_mult();
        int n;
        start_op(4'd1, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        n_tests++; if (n != 5) begin n_fail++; $display("FAIL mult_busy: got %0d expected 5", n); end
        n_tests++; if (E_HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h expected ffffffff", E_HI); end
        n_tests++; if (E_LO !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_lo: got %h expected fffffffe", E_LO); end
        E_MDUOp = 4'd8; #1;
        n_tests++; if (E_MDURe !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mflo: got %h expected fffffffe", E_MDURe); end
        E_MDUOp = 4'd7; #1;
        n_tests++; if (E_MDURe !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mfhi: got %h expected ffffffff", E_MDURe); end
        E_MDUOp = 4'd0; #1;
        n_tests++; if (E_MDURe !== 32'd0) begin n_fail++; $display("FAIL mdure_none: got %h expected 0", E_MDURe); end
    endtask

    task automatic test_multu();
        int n;
        start_op(4'd2, 32'hFFFF_FFFF, 32'd2);
        count_busy(n);
        n_tests++; if (n != 5) begin n_fail++; $display("FAIL multu_busy: got %0d expected 5", n); end
        n_tests++; if (E_HI !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h expected 00000001", E_HI); end
        n_tests++; if (E_LO !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h expected fffffffe", E_LO); end
    endtask

    task automatic test_div();
        int n;
        start_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        count_busy(n);
        n_tests++; if (n != 10) begin n_fail++; $display("FAIL div_busy: got %0d expected 10", n); end
        n_tests++; if (E_LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h expected fffffffd", E_LO); end
        n_tests++; if (E_HI !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h expected ffffffff", E_HI); end
        // Back-to-back launch in the first idle cycle; mflo while busy
        // must return the previous LO.
        start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        E_MDUOp = 4'd8; #1;
        n_tests++; if (E_MDURe !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL mflo_busy: got %h expected fffffffd", E_MDURe); end
        E_MDUOp = 4'd0;
        count_busy(n);
        n_tests++; if (n != 10) begin n_fail++; $display("FAIL divovf_busy: got %0d expected 10", n); end
        n_tests++; if (E_LO !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_lo: got %h expected 80000000", E_LO); end
        n_tests++; if (E_HI !== 32'd0) begin n_fail++; $display("FAIL divovf_hi: got %h expected 0", E_HI); end
        start_op(4'd3, 32'd7, 32'hFFFF_FFFE);
        count_busy(n);
        n_tests++; if (E_LO !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", E_LO); end
        n_tests++; if (E_HI !== 32'd1) begin n_fail++; $display("FAIL div_neg_hi: got %h expected 1", E_HI); end
        start_op(4'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(n);
        n_tests++; if (E_LO !== 32'd0) begin n_fail++; $display("FAIL divu_big_lo: got %h expected 0", E_LO); end
        n_tests++; if (E_HI !== 32'h8000_0000) begin n_fail++; $display("FAIL divu_big_hi: got %h expected 80000000", E_HI); end
        start_op(4'd4, 32'd100, 32'd7);
        count_busy(n);
        n_tests++; if (E_LO !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h expected 0000000e", E_LO); end
        n_tests++; if (E_HI !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h expected 2", E_HI); end
    endtask

    task automatic test_divzero();
        int n;
        move_to(4'd5, 32'h0000_1234);
        move_to(4'd6, 32'h0000_5678);
        n_tests++; if (E_HI !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi: got %h expected 00001234", E_HI); end
        n_tests++; if (E_LO !== 32'h0000_5678) begin n_fail++; $display("FAIL mtlo: got %h expected 00005678", E_LO); end
        start_op(4'd4, 32'd99, 32'd0);
        count_busy(n);
        n_tests++; if (n != 10) begin n_fail++; $display("FAIL divz_busy: got %0d expected 10", n); end
        n_tests++; if (E_HI !== 32'h0000_1234) begin n_fail++; $display("FAIL divz_hi: got %h expected 00001234", E_HI); end
        n_tests++; if (E_LO !== 32'h0000_5678) begin n_fail++; $display("FAIL divz_lo: got %h expected 00005678", E_LO); end
    endtask

    task automatic test_ignored_start();
        start_op(4'd0, 32'd3, 32'd4);
        n_tests++; if (E_Busy !== 1'b0) begin n_fail++; $display("FAIL start_op0: got %b expected 0", E_Busy); end
        start_op(4'd7, 32'd3, 32'd4);
        n_tests++; if (E_Busy !== 1'b0) begin n_fail++; $display("FAIL start_op7: got %b expected 0", E_Busy); end
`ifndef MDU_MADD_EN
        start_op(4'd9, 32'd3, 32'd4);
        n_tests++; if (E_Busy !== 1'b0) begin n_fail++; $display("FAIL start_op9: got %b expected 0", E_Busy); end
`endif
        n_tests++; if (E_HI !== 32'h0000_1234) begin n_fail++; $display("FAIL ignored_hi: got %h expected 00001234", E_HI); end
    endtask

    task automatic test_busy_start();
        int n;
        start_op(4'd1, 32'd3, 32'd4);
        // busy cycle 2: a stray div launch must be ignored
        E_MDUOp = 4'd3; E_A = 32'd100; E_B = 32'd7; E_Start = 1'b1;
        tick();
        E_Start = 1'b0;
        // busy cycle 3: mthi must be ignored
        E_MDUOp = 4'd5; E_A = 32'h0000_AAAA;
        tick();
        E_MDUOp = 4'd0;
        n_tests++; if (E_HI !== 32'h0000_1234) begin n_fail++; $display("FAIL busy_mthi: got %h expected 00001234", E_HI); end
        count_busy(n);
        n_tests++; if (n + 2 != 5) begin n_fail++; $display("FAIL busy_len: got %0d expected 5", n + 2); end
        n_tests++; if (E_HI !== 32'd0) begin n_fail++; $display("FAIL busy_hi: got %h expected 0", E_HI); end
        n_tests++; if (E_LO !== 32'd12) begin n_fail++; $display("FAIL busy_lo: got %h expected 0000000c", E_LO); end
    endtask

    task automatic test_abort();
        move_to(4'd5, 32'h0000_0055);
        start_op(4'd1, 32'd3, 32'd4);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_tests++; if (E_Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", E_Busy); end
        n_tests++; if (E_HI !== 32'd0) begin n_fail++; $display("FAIL abort_hi: got %h expected 0", E_HI); end
        n_tests++; if (E_LO !== 32'd0) begin n_fail++; $display("FAIL abort_lo: got %h expected 0", E_LO); end
        repeat (8) tick();
        n_tests++; if (E_HI !== 32'd0 || E_LO !== 32'd0 || E_Busy !== 1'b0) begin
            n_fail++; $display("FAIL abort_late: got hi=%h lo=%h busy=%b expected 0/0/0", E_HI, E_LO, E_Busy);
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int n;
        move_to(4'd5, 32'd0);
        move_to(4'd6, 32'hFFFF_FFFF);
        start_op(4'd10, 32'd1, 32'd1);
        count_busy(n);
        n_tests++; if (n != 5) begin n_fail++; $display("FAIL maddu_busy: got %0d expected 5", n); end
        n_tests++; if (E_HI !== 32'd1 || E_LO !== 32'd0) begin
            n_fail++; $display("FAIL maddu: got %h_%h expected 00000001_00000000", E_HI, E_LO);
        end
        start_op(4'd11, 32'd1, 32'd1);
        count_busy(n);
        n_tests++; if (E_HI !== 32'd0 || E_LO !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL msub: got %h_%h expected 00000000_ffffffff", E_HI, E_LO);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_divzero();
        test_ignored_start();
        test_busy_start();
        test_abort();
`ifdef MDU_MADD_EN
        test_madd();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
